md5_block_sequencer: RTL and testbench

MD5_BLOCK_SEQUENCER -- requirements
Module: md5_block_sequencer

---
 rtl/md5_pkg.sv | 51 +++++
 rtl/md5_block_sequencer_if.sv | 25 ++
 rtl/md5_step.sv | 44 ++++
 rtl/md5_block_sequencer.sv | 163 ++++++++++++++++
 tb/tb_md5_block_sequencer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/md5_pkg.sv
// Shared MD5 constants and types: IV, per-step sine constants, rotate amounts,
// round function select and sequencer FSM states.
package md5_pkg;

  localparam int unsigned WordBitsDefault = 32;
  localparam int unsigned BlockBits       = 512;
  localparam int unsigned DigestBits      = 128;

  localparam logic [31:0] IvA = 32'h67452301;
  localparam logic [31:0] IvB = 32'hefcdab89;
  localparam logic [31:0] IvC = 32'h98badcfe;
  localparam logic [31:0] IvD = 32'h10325476;

  // t_i = floor(abs(sin(i + 1)) * 2^32)
  localparam logic [31:0] TTable [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Indexed by {round, step[1:0]}
  localparam logic [4:0] ShiftTable [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

  typedef enum logic [1:0] {ModeF, ModeG, ModeH, ModeI} md5_mode_e;

  typedef enum logic [1:0] {StIdle, StRun, StDone} md5_state_e;

  // MD5 words are little-endian; the canonical digest is printed byte 0 first.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/md5_block_sequencer_if.sv
// Block-in / digest-out handshake bundle for the MD5 block sequencer.
interface md5_block_sequencer_if;
  import md5_pkg::*;

  logic                  i_valid;
  logic                  i_ready;
  logic                  i_first;
  logic [BlockBits-1:0]  i_block;
  logic                  o_valid;
  logic                  o_ready;
  logic [DigestBits-1:0] o_digest;

  // master: block producer / digest consumer
  modport master (
    output i_valid, i_first, i_block, o_ready,
    input  i_ready, o_valid, o_digest
  );

  // slave: the sequencer
  modport slave (
    input  i_valid, i_first, i_block, o_ready,
    output i_ready, o_valid, o_digest
  );

endinterface

// File: rtl/md5_step.sv
// One MD5 compression step: B' = B + rotl(A + f(B,C,D) + M + T, s), then rotate A..D.
module md5_step
  import md5_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  input  md5_mode_e   i_mode,
  input  logic [31:0] i_m,
  input  logic [31:0] i_t,
  input  logic [4:0]  i_s,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [31:0] o_c,
  output logic [31:0] o_d
);

  logic [31:0] w_f;
  logic [31:0] w_sum;
  logic [63:0] w_dbl;

  // Round function select
  always_comb begin
    w_f = '0;
    unique case (i_mode)
      ModeF: w_f = (i_b & i_c) | (~i_b & i_d);
      ModeG: w_f = (i_b & i_d) | (i_c & ~i_d);
      ModeH: w_f = i_b ^ i_c ^ i_d;
      ModeI: w_f = i_c ^ (i_b | ~i_d);
    endcase
  end

  // Add, rotate left via doubled word, and shuffle the registers
  always_comb begin
    w_sum = i_a + w_f + i_m + i_t;
    w_dbl = {w_sum, w_sum} << i_s;
    o_a   = i_d;
    o_b   = i_b + w_dbl[63:32];
    o_c   = i_b;
    o_d   = i_c;
  end

endmodule

// File: rtl/md5_block_sequencer.sv
// Iterative MD5 block engine: one step per cycle for 64 cycles, then a chaining
// add, then the digest is held until the consumer takes it.
module md5_block_sequencer
  import md5_pkg::*;
#(
  parameter int unsigned WORD_BITS = WordBitsDefault
) (
  input logic                  clk,
  input logic                  reset,
  md5_block_sequencer_if.slave bus
);

  md5_state_e r_state;
  md5_state_e w_state_next;

  logic [BlockBits-1:0] r_block;
  logic [WORD_BITS-1:0] r_a, r_b, r_c, r_d;
  logic [WORD_BITS-1:0] r_cv_a, r_cv_b, r_cv_c, r_cv_d;
  logic [5:0]           r_step;
  // Set once step 63 has run; the following edge does the chaining add.
  logic                 r_fin;

  logic       w_accept;
  logic       w_step_en;
  logic       w_finish;
  logic [1:0] w_round;
  md5_mode_e  w_mode;
  logic [3:0] w_k;
  logic [8:0] w_word_lsb;
  logic [31:0] w_m;
  logic [31:0] w_t;
  logic [4:0]  w_s;
  logic [31:0] w_a_new, w_b_new, w_c_new, w_d_new;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and datapath enables
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step_en    = 1'b0;
    w_finish     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.i_valid) begin
          w_accept     = 1'b1;
          w_state_next = StRun;
        end
      end
      StRun: begin
        if (r_fin) begin
          w_finish     = 1'b1;
          w_state_next = StDone;
        end else begin
          w_step_en = 1'b1;
        end
      end
      StDone: begin
        if (bus.o_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Per-step message word, constant and rotate selection
  always_comb begin
    w_round = r_step[5:4];
    w_mode  = md5_mode_e'(w_round);
    w_k     = r_step[3:0];
    unique case (w_round)
      2'd0: w_k = r_step[3:0];
      2'd1: w_k = r_step[3:0] * 4'd5 + 4'd1;
      2'd2: w_k = r_step[3:0] * 4'd3 + 4'd5;
      2'd3: w_k = r_step[3:0] * 4'd7;
    endcase
    w_word_lsb = {w_k, 5'd0};
    w_m        = r_block[w_word_lsb +: 32];
    w_t        = TTable[r_step];
    w_s        = ShiftTable[{w_round, r_step[1:0]}];
  end

  md5_step u_step (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_c    (r_c),
    .i_d    (r_d),
    .i_mode (w_mode),
    .i_m    (w_m),
    .i_t    (w_t),
    .i_s    (w_s),
    .o_a    (w_a_new),
    .o_b    (w_b_new),
    .o_c    (w_c_new),
    .o_d    (w_d_new)
  );

  // Working registers, step counter, block latch and chaining value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_block <= '0;
      r_a     <= IvA;
      r_b     <= IvB;
      r_c     <= IvC;
      r_d     <= IvD;
      r_cv_a  <= IvA;
      r_cv_b  <= IvB;
      r_cv_c  <= IvC;
      r_cv_d  <= IvD;
      r_step  <= '0;
      r_fin   <= 1'b0;
    end else if (w_accept) begin
      r_block <= bus.i_block;
      r_step  <= '0;
      r_fin   <= 1'b0;
      if (bus.i_first) begin
        // New message: both the working set and the chaining base restart at IV.
        r_a    <= IvA;
        r_b    <= IvB;
        r_c    <= IvC;
        r_d    <= IvD;
        r_cv_a <= IvA;
        r_cv_b <= IvB;
        r_cv_c <= IvC;
        r_cv_d <= IvD;
      end else begin
        r_a <= r_cv_a;
        r_b <= r_cv_b;
        r_c <= r_cv_c;
        r_d <= r_cv_d;
      end
    end else if (w_step_en) begin
      r_a <= w_a_new;
      r_b <= w_b_new;
      r_c <= w_c_new;
      r_d <= w_d_new;
      // Counter parks at 63; r_fin marks that the last step is done.
      if (r_step == 6'd63) begin
        r_fin <= 1'b1;
      end else begin
        r_step <= r_step + 6'd1;
      end
    end else if (w_finish) begin
      r_cv_a <= r_cv_a + r_a;
      r_cv_b <= r_cv_b + r_b;
      r_cv_c <= r_cv_c + r_c;
      r_cv_d <= r_cv_d + r_d;
    end
  end

  assign bus.i_ready  = (r_state == StIdle);
  assign bus.o_valid  = (r_state == StDone);
  assign bus.o_digest = {bswap32(r_cv_a), bswap32(r_cv_b), bswap32(r_cv_c), bswap32(r_cv_d)};

endmodule

// File: tb/tb_md5_block_sequencer.sv
// Directed bench for md5_block_sequencer using known MD5 test vectors.
module tb_md5_block_sequencer;

  localparam logic [127:0] DigIv    = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] DigEmpty = 128'hd41d8cd98f00b204e9800998ecf8427e;
  localparam logic [127:0] DigAbc   = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam logic [127:0] Dig80    = 128'h57edf4a22be3c955ac49da2e2107b67a;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  md5_block_sequencer_if bus_if ();

  md5_block_sequencer #(
    .WORD_BITS (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] msg [256];
  int         n_blocks;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pad a message into msg[]: 0x80, zeros, 64-bit little-endian bit length.
  task automatic load_msg(input string s);
    int len;
    len = s.len();
    for (int i = 0; i < 256; i++) msg[i] = 8'h00;
    for (int i = 0; i < len; i++) msg[i] = s[i];
    msg[len] = 8'h80;
    n_blocks = (len + 8) / 64 + 1;
    for (int j = 0; j < 8; j++) msg[n_blocks * 64 - 8 + j] = 8'((64'(len) * 8) >> (8 * j));
  endtask

  function automatic logic [511:0] get_block(input int b);
    logic [511:0] blk;
    blk = '0;
    for (int n = 0; n < 64; n++) blk[8 * n +: 8] = msg[64 * b + n];
    return blk;
  endfunction

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic offer(input logic [511:0] blk, input logic first, input logic hold);
    int n;
    n = 0;
    while (bus_if.i_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("offer_ready", 128'(bus_if.i_ready), 128'd1);
    bus_if.i_valid = 1'b1;
    bus_if.i_first = first;
    bus_if.i_block = blk;
    @(negedge clk);
    if (!hold) bus_if.i_valid = 1'b0;
  endtask

  // Entered just after accept edge T; returns just after edge T+65.
  task automatic wait_result(input string tag, input logic [127:0] exp);
    int busy_ready;
    int early_valid;
    busy_ready  = 0;
    early_valid = 0;
    if (bus_if.i_ready) busy_ready++;
    if (bus_if.o_valid) early_valid++;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (bus_if.i_ready) busy_ready++;
      if (bus_if.o_valid) early_valid++;
    end
    check({tag, "_no_early_valid"}, 128'(early_valid), 128'd0);
    check({tag, "_busy"}, 128'(busy_ready), 128'd0);
    @(negedge clk);
    check({tag, "_valid"}, 128'(bus_if.o_valid), 128'd1);
    check({tag, "_ready_low"}, 128'(bus_if.i_ready), 128'd0);
    check({tag, "_digest"}, bus_if.o_digest, exp);
  endtask

  task automatic take_digest(input string tag);
    bus_if.o_ready = 1'b1;
    @(negedge clk);
    bus_if.o_ready = 1'b0;
    check({tag, "_idle"}, 128'(bus_if.i_ready), 128'd1);
    check({tag, "_valid_drop"}, 128'(bus_if.o_valid), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    reset          = 1'b1;
    bus_if.i_valid = 1'b0;
    bus_if.i_first = 1'b0;
    bus_if.i_block = '0;
    bus_if.o_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 128'(bus_if.i_ready), 128'd1);
    check("reset_valid", 128'(bus_if.o_valid), 128'd0);
    check("reset_digest", bus_if.o_digest, DigIv);
    reset = 1'b0;
    @(negedge clk);

    // Empty message
    load_msg("");
    offer(get_block(0), 1'b1, 1'b0);
    wait_result("empty", DigEmpty);
    take_digest("empty");

    // "abc", then stall in DONE with a new block offered
    load_msg("abc");
    offer(get_block(0), 1'b1, 1'b0);
    wait_result("abc", DigAbc);
    load_msg("");
    bus_if.i_block = get_block(0);
    bus_if.i_first = 1'b1;
    bus_if.i_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus_if.o_valid !== 1'b1 || bus_if.o_digest !== DigAbc || bus_if.i_ready !== 1'b0) bad++;
    end
    check("stall_hold", 128'(bad), 128'd0);
    bus_if.i_valid = 1'b0;
    take_digest("abc");
    @(negedge clk);
    check("stall_ignored", 128'(bus_if.i_ready), 128'd1);

    // Two-block message, chaining value carried across
    load_msg({"1234567890", "1234567890", "1234567890", "1234567890",
              "1234567890", "1234567890", "1234567890", "1234567890"});
    check("two_blk_count", 128'(n_blocks), 128'd2);
    offer(get_block(0), 1'b1, 1'b0);
    repeat (65) @(negedge clk);
    check("two_blk0_valid", 128'(bus_if.o_valid), 128'd1);
    take_digest("two_blk0");
    offer(get_block(1), 1'b0, 1'b0);
    wait_result("two_blk", Dig80);
    take_digest("two_blk");

    // Reset at step 30 aborts the block and restores IV chaining
    load_msg("");
    offer(get_block(0), 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_ready", 128'(bus_if.i_ready), 128'd1);
    check("abort_valid", 128'(bus_if.o_valid), 128'd0);
    check("abort_digest", bus_if.o_digest, DigIv);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (bus_if.o_valid !== 1'b0) bad++;
    end
    check("abort_no_valid", 128'(bad), 128'd0);
    offer(get_block(0), 1'b0, 1'b0);
    wait_result("after_abort", DigEmpty);
    take_digest("after_abort");

    // i_valid held high throughout RUN; next block taken only after handshake
    load_msg("abc");
    offer(get_block(0), 1'b1, 1'b1);
    load_msg("");
    bus_if.i_block = get_block(0);
    wait_result("hold_abc", DigAbc);
    take_digest("hold_abc");
    @(negedge clk);
    bus_if.i_valid = 1'b0;
    wait_result("hold_next", DigEmpty);
    take_digest("hold_next");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
